// File: rtl/mem_arbiter.sv
// Memory arbiter: the CPU has absolute priority on a single-port synchronous RAM, and a
// background loader is served in idle cycles. Define MEM_ARB_STARVE_EN to build the starvation counter/flag.
module mem_arbiter #(
  parameter int AW           = 13,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 32
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          ld_busy,
  output logic          starve
);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_WAIT = 2'd1,
    L_ACC  = 2'd2,
    L_CAP  = 2'd3
  } ld_state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  ld_state_t     state;
  ld_state_t     state_next;
  logic          cpu_busy;
  logic          ld_grant;
  logic          cap_rd;
  logic [DW-1:0] ld_rdata_q;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  assign cpu_busy  = cpu_rd | cpu_wr;
  assign ld_grant  = (state == L_ACC) && !cpu_busy;
  assign cpu_rdata = mem_rdata;
  assign ld_ack    = (state == L_CAP);
  assign ld_busy   = (state != L_IDLE);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state <= L_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      L_IDLE: begin
        if (ld_req) begin
          state_next = cpu_busy ? L_WAIT : L_ACC;
        end
      end
      L_WAIT: begin
        if (!ld_req) begin
          state_next = L_IDLE;
        end else if (!cpu_busy) begin
          state_next = L_ACC;
        end
      end
      // Once here the access is committed; a CPU cycle only postpones it.
      L_ACC:   state_next = cpu_busy ? L_WAIT : L_CAP;
      L_CAP:   state_next = L_IDLE;
      default: state_next = L_IDLE;
    endcase
  end

  // Bus mux; when nobody drives, address and data keep their last values.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = hold_addr;
    mem_wdata = hold_wdata;
    if (cpu_busy) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_grant) begin
      mem_rd    = !ld_wr;
      mem_wr    = ld_wr;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (cpu_busy || ld_grant) begin
      hold_addr  <= mem_addr;
      hold_wdata <= mem_wdata;
    end
  end

  // The access type is latched at grant so a late change of ld_wr cannot alter the capture.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      cap_rd     <= 1'b0;
      ld_rdata_q <= '0;
    end else begin
      if (ld_grant) begin
        cap_rd <= !ld_wr;
      end
      if ((state == L_CAP) && cap_rd) begin
        ld_rdata_q <= mem_rdata;
      end
    end
  end

  // RAM data arrives in the ack cycle, so it is forwarded while the register loads.
  assign ld_rdata = (ld_ack && cap_rd) ? mem_rdata : ld_rdata_q;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (state == L_CAP) begin
      wait_cnt <= 8'd0;
    end else if ((state == L_WAIT) && ld_req && cpu_busy && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign starve = (wait_cnt >= STARVE_LIM8);
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural RAM, a cycle-level loader/bus model
// compared on every falling edge, and literal checks on hand-worked scenarios.
module tb_mem_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic          clk1 = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          ld_req = 1'b0;
  logic          ld_wr = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ld_busy;
  logic          starve;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] mmem [0:(1<<AW)-1];

  always #5 clk1 = ~clk1;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk1(clk1), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(ram_rdata),
    .ld_busy(ld_busy), .starve(starve)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 13'h0A5) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM: read data appears the cycle after mem_rd.
  initial begin : ram_model
    for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(AW'(i));
    forever begin
      @(posedge clk1);
      if (mem_rd) ram_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] = mem_wdata;
    end
  end

  // Loader model: a request seen with the CPU idle is served next idle cycle, acked the cycle after.
  initial begin : ref_model
    bit            m_try, m_ack, m_wait, m_acc_rd;
    bit            busy, grant, n_try, n_wait;
    int            m_cnt;
    logic [AW-1:0] m_last_addr, e_addr;
    logic [DW-1:0] m_last_wdata, m_rdata, m_acc_val, e_wdata, e_rdata;
    logic          e_rd, e_wr, e_starve;
    for (int i = 0; i < (1 << AW); i++) mmem[i] = init_val(AW'(i));
    m_try = 0; m_ack = 0; m_wait = 0; m_acc_rd = 0; m_cnt = 0;
    m_last_addr = '0; m_last_wdata = '0; m_rdata = '0; m_acc_val = '0;
    forever begin
      @(negedge clk1);
      if (!rst) begin
        m_try = 0; m_ack = 0; m_wait = 0; m_acc_rd = 0; m_cnt = 0;
        m_last_addr = '0; m_last_wdata = '0; m_rdata = '0;
      end
      busy  = cpu_rd | cpu_wr;
      grant = m_try && !busy;
      if (busy) begin
        e_rd = cpu_rd; e_wr = cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (grant) begin
        e_rd = !ld_wr; e_wr = ld_wr; e_addr = ld_addr; e_wdata = ld_wdata;
      end else begin
        e_rd = 0; e_wr = 0; e_addr = m_last_addr; e_wdata = m_last_wdata;
      end
      e_rdata = (m_ack && m_acc_rd) ? m_acc_val : m_rdata;
      e_starve = STARVE_ON ? (m_cnt >= LIMIT) : 1'b0;
      check_output("mem_rd", mem_rd, e_rd);
      check_output("mem_wr", mem_wr, e_wr);
      check_output("mem_addr", mem_addr, e_addr);
      check_output("mem_wdata", mem_wdata, e_wdata);
      check_output("ld_ack", ld_ack, m_ack);
      check_output("ld_rdata", ld_rdata, e_rdata);
      check_output("ld_busy", ld_busy, m_try || m_ack || m_wait);
      check_output("starve", starve, e_starve);
      check_output("cpu_rdata", cpu_rdata, ram_rdata);
      if (rst) begin
        n_try  = !m_try && !m_ack && ld_req && !busy;
        n_wait = (!m_try && !m_ack && ld_req && busy) || (m_try && busy);
        if (m_ack) m_cnt = 0;
        else if (m_wait && ld_req && busy && m_cnt < 255) m_cnt = m_cnt + 1;
        if (m_ack && m_acc_rd) m_rdata = m_acc_val;
        if (grant) begin
          m_acc_rd  = !ld_wr;
          m_acc_val = mmem[ld_addr];
        end
        if (busy || grant) begin
          m_last_addr  = e_addr;
          m_last_wdata = e_wdata;
        end
        m_ack  = grant;
        m_try  = n_try;
        m_wait = n_wait;
      end
      if (e_wr) mmem[e_addr] = e_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk1); #1;
  endtask

  task automatic chk_neg();
    @(negedge clk1); #1;
  endtask

  task automatic wait_ack(input string name, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n <= 40) begin
      chk_neg();
      if (ld_ack === 1'b1) seen = 1;
      else begin
        n = n + 1;
        cyc();
      end
    end
    if (!seen) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("[TB] FAIL %s: got no ld_ack, expected ack within 40 cycles", name);
    end else begin
      check_output({name, " latency"}, n, exp_lat);
    end
  endtask

  task automatic apply_stimulus();
    // Reset state, with CPU pass-through still live
    repeat (2) cyc();
    cpu_rd = 1; cpu_addr = 13'h1234;
    chk_neg();
    check_output("reset ld_ack", ld_ack, 0);
    check_output("reset ld_busy", ld_busy, 0);
    check_output("reset ld_rdata", ld_rdata, 0);
    check_output("reset starve", starve, 0);
    check_output("reset cpu mem_rd", mem_rd, 1);
    check_output("reset cpu mem_addr", mem_addr, 13'h1234);
    cyc(); cpu_rd = 0; rst = 1;
    repeat (2) cyc();

    // Idle-bus loader read
    ld_wr = 0; ld_addr = 13'h0A5; ld_req = 1;
    chk_neg(); check_output("rd c0 mem_rd", mem_rd, 0);
    cyc(); chk_neg();
    check_output("rd c1 mem_rd", mem_rd, 1);
    check_output("rd c1 mem_addr", mem_addr, 13'h0A5);
    cyc(); chk_neg();
    check_output("rd c2 ld_ack", ld_ack, 1);
    check_output("rd c2 ld_rdata", ld_rdata, 8'h3C);
    cyc(); ld_req = 0; chk_neg();
    check_output("rd c3 ld_ack", ld_ack, 0);
    check_output("rd c3 ld_rdata hold", ld_rdata, 8'h3C);
    cyc();

    // Loader write, then CPU read-back
    ld_wr = 1; ld_addr = 13'h100; ld_wdata = 8'h77; ld_req = 1;
    chk_neg(); check_output("wr c0 mem_wr", mem_wr, 0);
    cyc(); chk_neg();
    check_output("wr c1 mem_wr", mem_wr, 1);
    check_output("wr c1 mem_addr", mem_addr, 13'h100);
    check_output("wr c1 mem_wdata", mem_wdata, 8'h77);
    cyc(); chk_neg();
    check_output("wr c2 ld_ack", ld_ack, 1);
    check_output("wr c2 mem_wr", mem_wr, 0);
    check_output("wr c2 ld_rdata kept", ld_rdata, 8'h3C);
    cyc(); ld_req = 0; ld_wr = 0;
    cyc(); cpu_rd = 1; cpu_addr = 13'h100;
    cyc(); cpu_rd = 0;
    chk_neg(); check_output("cpu readback", cpu_rdata, 8'h77);
    cyc();

    // CPU read lands exactly in the loader's access cycle
    ld_addr = 13'h055; ld_req = 1;
    cyc(); cpu_rd = 1; cpu_addr = 13'h0A5;
    chk_neg();
    check_output("preempt mem_rd", mem_rd, 1);
    check_output("preempt mem_addr", mem_addr, 13'h0A5);
    cyc(); cpu_rd = 0;
    chk_neg();
    check_output("preempt wait mem_rd", mem_rd, 0);
    check_output("preempt wait ld_busy", ld_busy, 1);
    check_output("preempt cpu_rdata", cpu_rdata, 8'h3C);
    cyc(); chk_neg();
    check_output("retry mem_addr", mem_addr, 13'h055);
    check_output("retry mem_rd", mem_rd, 1);
    cyc(); chk_neg();
    check_output("retry ld_ack", ld_ack, 1);
    check_output("retry ld_rdata", ld_rdata, 8'h0F);
    cyc(); ld_req = 0;

    // Simultaneous CPU read and write are forwarded untouched
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 13'h200; cpu_wdata = 8'h99;
    chk_neg();
    check_output("both mem_rd", mem_rd, 1);
    check_output("both mem_wr", mem_wr, 1);
    check_output("both mem_wdata", mem_wdata, 8'h99);
    cyc(); cpu_rd = 0; cpu_wr = 0;

    // Request behind a CPU write, then a back-to-back request
    ld_addr = 13'h200; ld_req = 1; cpu_wr = 1; cpu_addr = 13'h300; cpu_wdata = 8'h11;
    cyc(); cpu_wr = 0;
    wait_ack("after cpu write", 2);
    check_output("after cpu write ld_rdata", ld_rdata, 8'h99);
    cyc(); ld_addr = 13'h300;
    wait_ack("back-to-back", 2);
    check_output("back-to-back ld_rdata", ld_rdata, 8'h11);
    cyc(); ld_req = 0; cyc();

    // Long CPU burst with a pending loader read
    cpu_addr = 13'h010; ld_addr = 13'h011; ld_req = 1;
    for (int i = 0; i < 10; i++) begin
      cpu_rd = 1;
      chk_neg();
      if (i == 5) check_output("starve raised", starve, STARVE_ON);
      cyc();
    end
    cpu_rd = 0;
    wait_ack("starved read", 2);
    check_output("starve at ack", starve, STARVE_ON);
    check_output("starved ld_rdata", ld_rdata, 8'h4B);
    cyc(); ld_req = 0;
    chk_neg(); check_output("starve cleared", starve, 0);
    cyc();

    // Reset pulse during the capture cycle
    ld_addr = 13'h0A5; ld_req = 1;
    cyc(); chk_neg(); check_output("rst c1 mem_rd", mem_rd, 1);
    cyc(); rst = 0;
    chk_neg();
    check_output("rst cap ld_ack", ld_ack, 0);
    check_output("rst cap ld_rdata", ld_rdata, 0);
    check_output("rst cap ld_busy", ld_busy, 0);
    cyc(); rst = 1;
    wait_ack("re-request", 2);
    check_output("re-request ld_rdata", ld_rdata, 8'h3C);
    cyc(); ld_req = 0; cyc();

    // Request withdrawn while waiting
    cpu_rd = 1; cpu_addr = 13'h040; ld_addr = 13'h020; ld_req = 1;
    cyc(); cyc(); ld_req = 0;
    chk_neg(); check_output("abandon ld_busy", ld_busy, 1);
    cyc(); cpu_rd = 0;
    chk_neg();
    check_output("abandon idle", ld_busy, 0);
    check_output("abandon mem_rd", mem_rd, 0);
    cyc(); chk_neg(); check_output("abandon no ack", ld_ack, 0);
    cyc();

    ld_addr = 13'h100; ld_req = 1;
    wait_ack("final read", 2);
    check_output("final ld_rdata", ld_rdata, 8'h77);
    cyc(); ld_req = 0;
    repeat (3) cyc();
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
